// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: bundles the requester-side and SPI-master-side signals
// of spi_txn_arbiter.
//
// Signals:
//   req       requesters -> arbiter   level request, one bit per requester
//   cmd_in    requesters -> arbiter   flattened 16-bit commands, requester i at [16i+15:16i]
//   ack       arbiter -> requesters   one-cycle completion pulse to the served requester
//   rsp_data  arbiter -> requesters   received word, valid with ack, held until next capture
//   err       arbiter -> requesters   pulses with ack when the transaction timed out
//   busy      arbiter -> observers    high whenever the arbiter is not idle
//   wrt       arbiter -> SPI master   one-cycle start pulse
//   spi_cmd   arbiter -> SPI master   command word for the transfer
//   spi_done  SPI master -> arbiter   one-cycle done pulse
//   spi_rdata SPI master -> arbiter   received word, valid with spi_done
//   spi_ss_n  SPI master -> arbiter   master's active-low select
//   ss_n      arbiter -> slaves       per-slave active-low selects
//   dbg_state arbiter -> observers    current FSM state encoding
//
// Handshake: a requester raises req[i] and keeps it and cmd_in[i] stable until
// it samples ack[i]; it drops req[i] on that same edge. ack is a single-cycle
// pulse and is the only completion indication (err qualifies it). On the SPI
// side, wrt is a single-cycle start and spi_done is a single-cycle completion;
// spi_done is only honoured while a transfer is outstanding.
interface spi_txn_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] cmd_in;
  logic [NUM_REQ-1:0]    ack;
  logic [15:0]           rsp_data;
  logic                  err;
  logic                  busy;
  logic                  wrt;
  logic [15:0]           spi_cmd;
  logic                  spi_done;
  logic [15:0]           spi_rdata;
  logic                  spi_ss_n;
  logic [NUM_REQ-1:0]    ss_n;
  logic [1:0]            dbg_state;

  modport master (
    input  req, cmd_in, spi_done, spi_rdata, spi_ss_n,
    output ack, rsp_data, err, busy, wrt, spi_cmd, ss_n, dbg_state
  );

  modport slave (
    output req, cmd_in, spi_done, spi_rdata, spi_ss_n,
    input  ack, rsp_data, err, busy, wrt, spi_cmd, ss_n, dbg_state
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter/sequencer sharing one 16-bit SPI master
// between NUM_REQ requesters. The winner's command is launched with a wrt
// pulse, the master's select is routed only to the granted slave, and the
// received word is returned with a one-cycle ack. A watchdog aborts a
// transfer whose done never arrives, returning 0 with err set.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  spi_txn_arbiter_if master modport (see interface file for signals)
//
// Parameters:
//   NUM_REQ  number of requesters / slave selects (2..8)
//   TIMEOUT  WAIT-state cycles before a transfer is aborted (>= 600)
module spi_txn_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_txn_arbiter_if.master    bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_found;
  logic [TMR_W-1:0]   timer;
  logic               timed_out;
  logic               err_flag;
  logic [15:0]        spi_cmd_q;
  logic [15:0]        rsp_data_q;
  logic [NUM_REQ-1:0] ack_c;
  logic [NUM_REQ-1:0] ss_n_c;
  logic               busy_c;

  // Round-robin search: walk the indices starting just after the last grant,
  // wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (win_found) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.spi_done || timed_out) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers. spi_done has priority over the watchdog when both
  // land on the same cycle, so a late-but-valid word is never discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      last       <= IDX_W'(NUM_REQ - 1);
      timer      <= '0;
      spi_cmd_q  <= '0;
      rsp_data_q <= '0;
      err_flag   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            gnt       <= win_idx;
            spi_cmd_q <= bus.cmd_in[{win_idx, 4'b0000} +: 16];
          end
        end
        ST_LAUNCH: begin
          last  <= gnt;
          timer <= '0;
        end
        ST_WAIT: begin
          timer <= timer + TMR_W'(1);
          if (bus.spi_done) begin
            rsp_data_q <= bus.spi_rdata;
            err_flag   <= 1'b0;
          end else if (timed_out) begin
            rsp_data_q <= 16'h0000;
            err_flag   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state
  assign busy_c = (state != ST_IDLE);

  always_comb begin
    ack_c = '0;
    if (state == ST_RESP) ack_c[gnt] = 1'b1;
  end

  // Only the granted slave follows the master's select; all others stay high.
  always_comb begin
    ss_n_c = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      ss_n_c[i] = bus.spi_ss_n | ~(busy_c & (gnt == IDX_W'(i)));
    end
  end

  assign bus.ack       = ack_c;
  assign bus.err       = (state == ST_RESP) & err_flag;
  assign bus.busy      = busy_c;
  assign bus.wrt       = (state == ST_LAUNCH);
  assign bus.spi_cmd   = spi_cmd_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.ss_n      = ss_n_c;
  assign bus.dbg_state = state;

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter and sequencer that shares one 16-bit full-duplex SPI master between `NUM_REQ` requesters, such as sensor or ADC front ends. It sits between the requesters and the SPI master. It accepts a command from the winning requester and pulses the master's `wrt`. It fans the master's single `SS_n` out to one chip select per slave, waits for `done`, and returns the received word with a one-cycle acknowledge. A watchdog frees the arbiter if `done` never arrives.

## Interface
- `NUM_REQ`, default 4: number of requesters and slave selects; legal range 2..8.
- `TIMEOUT`, default 1024: WAIT-state cycles before a transaction is aborted; must be at least 600.
- `clk`  in  1  system clock.
- `rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `req`  in  NUM_REQ  level request per requester; held high until its `ack`.
- `cmd_in`  in  16*NUM_REQ  flattened commands; requester i at bits [16i+15:16i]; stable while `req[i]` is high.
- `ack`  out  NUM_REQ  one-cycle completion pulse to the served requester.
- `rsp_data`  out  16  word received from the slave; valid with `ack`; held until the next capture.
- `err`  out  1  pulses together with `ack` when the transaction timed out.
- `busy`  out  1  high in every state except IDLE.
- `wrt`  out  1  start pulse to the SPI master.
- `spi_cmd`  out  16  command to the SPI master.
- `spi_done`  in  1  registered one-cycle done pulse from the SPI master.
- `spi_rdata`  in  16  SPI master receive data; valid when `spi_done` is high.
- `spi_ss_n`  in  1  active-low select from the SPI master.
- `ss_n`  out  NUM_REQ  per-slave active-low selects.

## Operation
- **States:** IDLE, LAUNCH, WAIT, RESP.
- **IDLE:**
  - If any `req` bit is high, pick a winner by round-robin.
  - The search starts at `last+1` (mod NUM_REQ) and takes the first set bit.
  - Register the winner's index in `gnt` and its command in `spi_cmd`, then go to LAUNCH.
  - If no `req` bit is high, stay in IDLE.
- **LAUNCH:** `wrt`=1 for exactly this one cycle; `last` <= `gnt`; go to WAIT.
- **WAIT:**
  - The timer is cleared on entry and increments every WAIT cycle.
  - On `spi_done`, capture `rsp_data` <= `spi_rdata`, set the err flag to 0, and go to RESP.
  - If the timer reaches TIMEOUT-1 without `spi_done`, set `rsp_data` <= 16'h0000, set the err flag to 1, and go to RESP.
  - If both conditions occur in the same cycle, `spi_done` wins.
- **RESP:** `ack[gnt]`=1 and `err`=err flag for this one cycle; go to IDLE.
- **Chip-select fan-out:** `ss_n[i] = spi_ss_n | ~(busy & gnt==i)`. Only the granted slave sees the master's select; all other selects stay high.
- **Ignored inputs:**
  - `spi_done` outside WAIT is ignored.
  - `req` changes outside IDLE are ignored.
- **Requester obligation:** deassert `req[i]` on the clock edge that samples `ack[i]`. This guarantees at least one IDLE cycle before that index is re-arbitrated.
- **Timer width:** clog2(TIMEOUT+1) bits; no wrap, because the timer is cleared on WAIT entry.

## Timing
- **Reset values (`rst` sampled high at a clk edge):**
  - State is IDLE and `last` = NUM_REQ-1, so index 0 has first priority.
  - `ack`=0, `err`=0, `busy`=0, `wrt`=0, `spi_cmd`=0, `rsp_data`=0.
  - `ss_n` is all ones.
- **Reset mid-transaction:** the transaction is dropped and no `ack` is issued.
- **Grant latency:** `req` sampled at edge E gives LAUNCH (`wrt`=1) during E..E+1 and WAIT from E+1.
- **Minimum IDLE-to-ack:** 3 cycles plus the SPI transfer length.
- **Done-to-ack latency:** `spi_done` sampled at edge D gives `ack`/`rsp_data` valid during D..D+1; the arbiter is back in IDLE at D+1.
- **Timeout:** WAIT entered at edge W gives `ack`+`err` during W+TIMEOUT..W+TIMEOUT+1.
- **Output registration:**
  - `wrt`, `ack`, `err` and `busy` are decoded from registered state.
  - `spi_cmd` and `rsp_data` are registers.
  - `ss_n` is combinational from `spi_ss_n`.
- **Pulse widths:** `wrt` is never high for more than one cycle per grant; at most one `ack` bit is high at a time.

## Test plan
- **Single request:** `req`=4'b0100, `cmd_in[2]`=16'hDEAD; slave model returns 16'hBEEF.
  - `wrt` pulses once, 1 cycle after `req` is sampled; `spi_cmd`=16'hDEAD.
  - `ss_n`=4'b1011 while `spi_ss_n` is low, otherwise 4'b1111.
  - `ack`=4'b0100 with `rsp_data`=16'hBEEF and `err`=0.
- **Contention:** `req`=4'b1011 from reset.
  - Service order is 0, 1, 3; exactly three `wrt` pulses; each `ack` matches its requester's returned data.
  - Then `req`=4'b1001 with `last`=3: order is 0 then 3.
- **Timeout:** `spi_done` tied low after `wrt`.
  - `ack` for the granted index with `err`=1 and `rsp_data`=16'h0000, exactly TIMEOUT cycles after WAIT entry.
  - The next request is then served normally.
- **Coincident done and timeout:** `spi_done` on the timeout cycle.
  - `err`=0 and `rsp_data`=`spi_rdata`.
- **Spurious done:** `spi_done` pulses while IDLE.
  - No `ack`, `busy` stays 0, `rsp_data` unchanged.
- **Reset mid-WAIT:** `rst`=1 for one edge mid-WAIT.
  - Next cycle: `busy`=0, `ss_n`=all ones, no `ack`.
  - Index 0 has priority at the next arbitration.
